// File: rtl/fle_serial_adder_seq_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encodings and the legal operand width range.
package fle_serial_adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/fle_serial_shreg.sv
// WIDTH-bit right-shift register with parallel load and optional
// invert-on-load; load takes priority over shift.
module fle_serial_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_inv,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_inv ? ~i_din : i_din;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fle_serial_adder_seq.sv
// Bit-serial add/subtract sequencer driving one external full-adder cell
// LSB-first and collecting its sum bits into a result register.
module fle_serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    input  logic             sub,
    output logic             adder_a,
    output logic             adder_b,
    output logic             adder_cin,
    input  logic             adder_sumout,
    input  logic             adder_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    import fle_serial_adder_seq_pkg::*;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_run;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_q;
    logic [WIDTH-1:0] w_b_q;
    logic [WIDTH-1:0] w_sum_q;
    logic             w_unused;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = start && !w_run;

    fle_serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_accept),
        .i_inv   (1'b0),
        .i_din   (op_a),
        .i_shift (w_run),
        .i_sin   (1'b0),
        .o_q     (w_a_q)
    );

    // Subtraction is A + ~B + 1: B is inverted on load, the +1 is the seed carry.
    fle_serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_accept),
        .i_inv   (sub),
        .i_din   (op_b),
        .i_shift (w_run),
        .i_sin   (1'b0),
        .o_q     (w_b_q)
    );

    fle_serial_shreg #(.WIDTH(WIDTH)) u_sum_sh (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_accept),
        .i_inv   (1'b0),
        .i_din   ('0),
        .i_shift (w_run),
        .i_sin   (adder_sumout),
        .o_q     (w_sum_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_c_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_carry <= sub ? 1'b1 : cin_init;
                        r_cnt   <= '0;
                        r_c_msb <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_carry <= adder_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (r_cnt == CNT_MSB) begin
                        r_c_msb <= adder_cout;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_sum   <= {adder_sumout, w_sum_q[WIDTH-1:1]};
                        r_cout  <= adder_cout;
                        r_ovf   <= r_c_msb ^ adder_cout;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign adder_a   = w_run & w_a_q[0];
    assign adder_b   = w_run & w_b_q[0];
    assign adder_cin = w_run & r_carry;

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

    assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1], w_sum_q[0]};

endmodule
